// File: rtl/adder_32.sv
// adder_32: registered two-operand adder built on a two-level carry-lookahead tree.
// 4-bit lookahead groups feed a second-level lookahead that forms every group carry-in
// directly from group generate/propagate, so no carry ripples between groups.
// Result and status flags are registered once: one-cycle latency, full throughput.
module adder_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid_in,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             valid_out
);

    localparam int unsigned GRP_W = 4;
    localparam int unsigned NG    = WIDTH / GRP_W;
    localparam int unsigned MSB   = WIDTH - 1;

    // Group-level generate/propagate and carry into each group (index NG is the final carry)
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_zero;

    // Adder has no carry-in; kept as an explicit term so the lookahead equations stay uniform
    assign w_cin[0] = 1'b0;

    // First level: per-bit g/p, in-group carries, group G/P and sum bits
    for (genvar gi = 0; gi < int'(NG); gi++) begin : g_grp
        localparam int unsigned LSB = gi * GRP_W;

        logic [GRP_W-1:0] w_g;
        logic [GRP_W-1:0] w_p;
        logic [GRP_W-1:0] w_c;

        assign w_g = a[LSB +: GRP_W] & b[LSB +: GRP_W];
        assign w_p = a[LSB +: GRP_W] ^ b[LSB +: GRP_W];

        // In-group carries, each a flat sum-of-products from the group carry-in
        assign w_c[0] = w_cin[gi];
        assign w_c[1] = w_g[0]
                      | (w_p[0] & w_cin[gi]);
        assign w_c[2] = w_g[1]
                      | (w_p[1] & w_g[0])
                      | (w_p[1] & w_p[0] & w_cin[gi]);
        assign w_c[3] = w_g[2]
                      | (w_p[2] & w_g[1])
                      | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_cin[gi]);

        // Group generate/propagate, independent of the group carry-in
        assign w_gg[gi] = w_g[3]
                        | (w_p[3] & w_g[2])
                        | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_gp[gi] = &w_p;

        assign w_sum[LSB +: GRP_W] = w_p ^ w_c;
    end

    // Second level: carry into group j = OR over k<j of G[k] propagated through groups k+1..j-1
    for (genvar gj = 1; gj <= int'(NG); gj++) begin : g_lvl2
        logic [NG:0] w_term;

        for (genvar gk = 0; gk < int'(NG); gk++) begin : g_term
            if (gk == gj - 1) begin : g_adj
                assign w_term[gk] = w_gg[gk];
            end else if (gk < gj - 1) begin : g_far
                assign w_term[gk] = w_gg[gk] & (&w_gp[gj-1:gk+1]);
            end else begin : g_none
                assign w_term[gk] = 1'b0;
            end
        end

        // Carry-in term propagated through every lower group
        assign w_term[NG] = (&w_gp[gj-1:0]) & w_cin[0];

        assign w_cin[gj] = |w_term;
    end

    // Status flags derived from the combinational sum
    assign w_ovf  = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
    assign w_zero = ~|w_sum;

    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_valid;

    // Output registers load every cycle; valid_out only tags the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_sum;
            r_carry <= w_cin[NG];
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
            r_valid <= valid_in;
        end
    end

    assign y         = r_y;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed vector table, async-reset sequences and randomized checks
// against an arithmetic reference model, on a 32-bit and an 8-bit instance.
module tb_adder_32;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        valid_in;
    logic [31:0] y;
    logic        carry_out, overflow, zero, valid_out;

    logic [7:0]  a8, b8;
    logic        valid_in8;
    logic [7:0]  y8;
    logic        carry_out8, overflow8, zero8, valid_out8;

    int n_tests;
    int n_fail;

    adder_32 #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .valid_in(valid_in),
        .y(y), .carry_out(carry_out), .overflow(overflow), .zero(zero), .valid_out(valid_out)
    );

    adder_32 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .valid_in(valid_in8),
        .y(y8), .carry_out(carry_out8), .overflow(overflow8), .zero(zero8), .valid_out(valid_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        vin;
        logic [31:0] y;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [31:0] y;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic res_t model(input longint unsigned ua, input longint unsigned ub, input int w);
        res_t              r;
        longint unsigned   modv;
        longint unsigned   full;
        longint            half;
        longint            sa, sb, ss;
        modv = 64'd1 << w;
        half = longint'(64'd1 << (w - 1));
        full = ua + ub;
        r.y  = 32'(full % modv);
        r.co = (full >= modv);
        r.z  = ((full % modv) == 64'd0);
        sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(modv) : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(modv) : longint'(ub);
        ss   = sa + sb;
        r.ov = (ss >= half) || (ss < -half);
        return r;
    endfunction

    // Operand picker biased toward edge values
    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    vec_t tab[11];
    res_t e32, e8;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        valid_in = 1'b1;
        a8       = 8'h5A;
        b8       = 8'hC3;
        valid_in8 = 1'b1;

        tab[0]  = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
        tab[2]  = '{32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0};
        tab[3]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tab[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tab[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tab[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tab[7]  = '{32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tab[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        tab[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tab[10] = '{32'h0000_000A, 32'h0000_0014, 1'b1, 32'h0000_001E, 1'b0, 1'b0, 1'b0};

        // Async reset: outputs clear before any clock edge
        #3 rst = 1'b1;
        #1;
        check("rst_async_y",     64'(y),         64'h0);
        check("rst_async_co",    64'(carry_out), 64'h0);
        check("rst_async_ov",    64'(overflow),  64'h0);
        check("rst_async_zero",  64'(zero),      64'h1);
        check("rst_async_vout",  64'(valid_out), 64'h0);
        check("rst_async_y8",    64'(y8),        64'h0);
        check("rst_async_zero8", 64'(zero8),     64'h1);

        // Outputs hold while reset stays high across edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y",    64'(y),         64'h0);
        check("rst_hold_co",   64'(carry_out), 64'h0);
        check("rst_hold_zero", 64'(zero),      64'h1);
        check("rst_hold_vout", 64'(valid_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, back to back, one-cycle latency
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a        = tab[i].a;
            b        = tab[i].b;
            valid_in = tab[i].vin;
            if (i > 0) begin
                #1;
                check($sformatf("v%0d_hold_y", i), 64'(y), 64'(tab[i-1].y));
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_y", i),    64'(y),         64'(tab[i].y));
            check($sformatf("v%0d_co", i),   64'(carry_out), 64'(tab[i].co));
            check($sformatf("v%0d_ov", i),   64'(overflow),  64'(tab[i].ov));
            check($sformatf("v%0d_zero", i), 64'(zero),      64'(tab[i].z));
            check($sformatf("v%0d_vout", i), 64'(valid_out), 64'(tab[i].vin));
        end

        // Reset pulse between edges discards the in-flight result
        @(negedge clk);
        a        = 32'h0000_0005;
        b        = 32'h0000_0003;
        valid_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_y",    64'(y),         64'h0);
        check("mid_rst_vout", 64'(valid_out), 64'h0);
        check("mid_rst_zero", 64'(zero),      64'h1);
        check("mid_rst_co",   64'(carry_out), 64'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_y",    64'(y),         64'h8);
        check("post_rst_vout", 64'(valid_out), 64'h1);
        check("post_rst_zero", 64'(zero),      64'h0);

        // Randomized operands on both widths against the reference model
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            a         = pick32();
            b         = pick32();
            valid_in  = 1'($urandom_range(0, 1));
            a8        = 8'($urandom);
            b8        = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b8 = 8'(-a8);
            valid_in8 = 1'($urandom_range(0, 1));
            e32 = model(64'(a), 64'(b), 32);
            e8  = model(64'(a8), 64'(b8), 8);
            @(posedge clk);
            #1;
            check("rnd32", {27'h0, valid_out, zero, overflow, carry_out, y},
                           {27'h0, valid_in, e32.z, e32.ov, e32.co, e32.y});
            check("rnd8",  {51'h0, valid_out8, zero8, overflow8, carry_out8, y8},
                           {51'h0, valid_in8, e8.z, e8.ov, e8.co, e8.y[7:0]});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
